instruction_fetch_unit: RTL

- Initiator side of the instruction-memory read interface in the IF stage.
- Owns the fetch PC and drives a word address to the combinational instruction memory every cycle.
- Captures the returned word with its PC+4 into a small prefetch queue.
- Presents queued instructions to the IF/ID boundary through a valid/ready handshake; a taken branch from EXE flushes the queue and redirects fetch.

---
 rtl/instruction_fetch_unit_pkg.sv | 26 ++
 rtl/instruction_fetch_unit_fetch_queue.sv | 69 ++++++
 rtl/instruction_fetch_unit.sv | 75 +++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_pkg : shared widths, PC step and prefetch entry type
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package instruction_fetch_unit_pkg;

    localparam int WORD_LEN    = 32;
    localparam int ADDRESS_LEN = 32;

    localparam logic [ADDRESS_LEN-1:0] PC_INCREMENT = 32'd4;
    localparam logic [ADDRESS_LEN-1:0] ALIGN_MASK   = 32'h0000_0003;

    typedef struct packed {
        logic [ADDRESS_LEN-1:0] pc_plus4;
        logic [WORD_LEN-1:0]    instruction;
    } fetch_entry_t;

    function automatic logic [ADDRESS_LEN-1:0] word_align(input logic [ADDRESS_LEN-1:0] addr);
        return addr & ~ALIGN_MASK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue : synchronous prefetch FIFO with flush, count and head read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 wr_data,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    // Storage is deliberately left out of reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit : IF-stage fetch PC, imem request and prefetch queue
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [ADDRESS_LEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                     QUEUE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDRESS_LEN-1:0] imem_address,
    input  logic [WORD_LEN-1:0]    imem_instruction,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_address,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LEN-1:0]    out_instruction,
    output logic [ADDRESS_LEN-1:0] out_pc
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH+1);

    logic [ADDRESS_LEN-1:0] r_fetch_pc;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic                   w_full;
    logic [CNT_W-1:0]       w_count;
    fetch_entry_t           w_wr_entry;
    fetch_entry_t           w_head;

    assign w_pop  = out_valid && out_ready;
    // A full queue can still accept the new word when the head leaves this cycle.
    assign w_push = !branch_taken && (!w_full || w_pop);

    assign w_wr_entry.pc_plus4    = r_fetch_pc + PC_INCREMENT;
    assign w_wr_entry.instruction = imem_instruction;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (branch_taken) begin
            r_fetch_pc <= word_align(branch_address);
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + PC_INCREMENT;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (branch_taken),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data (w_wr_entry),
        .head    (w_head),
        .count   (w_count),
        .empty   (w_empty),
        .full    (w_full)
    );

    assign imem_address    = r_fetch_pc;
    assign out_valid       = !w_empty;
    assign out_instruction = w_head.instruction;
    assign out_pc          = w_head.pc_plus4;

endmodule

`default_nettype wire
